// File: rtl/uart_word_bridge_pkg.sv
// Shared types and constants for the word-to-byte UART bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_word_bridge_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_LOAD = 2'd1,
    T_SEND = 2'd2,
    T_WAIT = 2'd3
  } tx_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

  localparam int DROP_CNT_W = 8;

  // Byte index width; a one-byte word still needs a 1-bit index register.
  function automatic int byte_idx_w(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

endpackage

// File: rtl/uart_word_bridge_if.sv
// Byte-level handshake between the bridge and the UART core.
// Latency: n/a (wires only).
// Backpressure: tx launch waits for the tx_rdy completion pulse; rx byte held until acked.
interface uart_word_bridge_if;
  logic [7:0] byte_tx_data;
  logic       byte_tx_vld;
  logic       byte_tx_rdy;
  logic [7:0] byte_rx_data;
  logic       byte_rx_rdy;
  logic       byte_rx_ack;

  modport master (
    output byte_tx_data, byte_tx_vld, byte_rx_ack,
    input  byte_tx_rdy, byte_rx_data, byte_rx_rdy
  );

  modport slave (
    input  byte_tx_data, byte_tx_vld, byte_rx_ack,
    output byte_tx_rdy, byte_rx_data, byte_rx_rdy
  );
endinterface

// File: rtl/uart_word_bridge_sync_fifo.sv
// Single-clock FIFO of 2^DEPTH_IDX entries with an occupancy output.
// Latency: pop_data/pop_vld registered, valid the cycle after an accepted pop.
// Backpressure: push refused when level is full, pop ignored when empty (level before the edge decides).
module sync_fifo #(
  parameter int W         = 8,
  parameter int DEPTH_IDX = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop,
  output logic [W-1:0]         pop_data,
  output logic                 pop_vld,
  output logic [DEPTH_IDX:0]   level
);
  localparam int DEPTH = 1 << DEPTH_IDX;

  logic [W-1:0]           mem [DEPTH];
  logic [DEPTH_IDX-1:0]   wr_ptr;
  logic [DEPTH_IDX-1:0]   rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign do_push = push && (level != (DEPTH_IDX+1)'(DEPTH));
  assign do_pop  = pop && (level != '0);

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pop_data <= '0;
      pop_vld  <= 1'b0;
    end else begin
      pop_vld <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + DEPTH_IDX'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + DEPTH_IDX'(1);
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (DEPTH_IDX+1)'(1);
        2'b01:   level <= level - (DEPTH_IDX+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_word_bridge.sv
// Word<->byte bridge: request words go out LSB byte first, inbound bytes are packed into response words.
// Latency: first tx byte 3 clks after request handshake; rx word in rsp_level 2 clks after last byte_rx_rdy.
// Backpressure: req_rdy_o low when request FIFO full; full response FIFO drops whole words (counted).
// Optional inter-byte rx timeout enabled by defining UART_WORD_BRIDGE_RX_TIMEOUT_EN.
module uart_word_bridge
  import uart_word_bridge_pkg::*;
#(
  parameter int WORD_BYTES        = 4,
  parameter int REQ_DEPTH_IDX     = 5,
  parameter int RSP_DEPTH_IDX     = 5,
  parameter int RX_TIMEOUT_CYCLES = 50000,
  localparam int WORD_W           = 8 * WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_W-1:0]       req_data_i,
  input  logic                    req_vld_i,
  output logic                    req_rdy_o,
  input  logic                    rsp_r_en,
  output logic [WORD_W-1:0]       rsp_data_o,
  output logic                    rsp_data_o_vld,
  uart_word_bridge_if.master      uart,
  output logic [REQ_DEPTH_IDX:0]  req_level,
  output logic [RSP_DEPTH_IDX:0]  rsp_level,
  output logic [DROP_CNT_W-1:0]   rx_drop_cnt,
  output logic                    rsp_overflow
);
  localparam int IDX_W = byte_idx_w(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  tx_state_t          tx_state;
  rx_state_t          rx_state;
  logic [IDX_W-1:0]   tx_idx;
  logic [IDX_W-1:0]   rx_idx;
  logic [WORD_W-1:0]  tx_word;
  logic [WORD_W-1:0]  rx_asm;
  logic               rx_done;
  logic               rdy_en;
  logic               req_push;
  logic               req_pop;
  logic [WORD_W-1:0]  req_pop_data;
  logic               req_pop_vld;
  logic               rsp_push;
  logic               rsp_full;
  logic               rx_capture;

  assign req_rdy_o  = rdy_en && !req_level[REQ_DEPTH_IDX];
  assign req_push   = req_vld_i && req_rdy_o;
  assign req_pop    = (tx_state == T_LOAD);
  assign rsp_full   = rsp_level[RSP_DEPTH_IDX];
  assign rsp_push   = (rx_state == R_ACK) && rx_done;
  assign rx_capture = (rx_state == R_IDLE) && uart.byte_rx_rdy;

  sync_fifo #(.W(WORD_W), .DEPTH_IDX(REQ_DEPTH_IDX)) u_req_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(req_push), .push_data(req_data_i),
    .pop(req_pop), .pop_data(req_pop_data), .pop_vld(req_pop_vld),
    .level(req_level)
  );

  sync_fifo #(.W(WORD_W), .DEPTH_IDX(RSP_DEPTH_IDX)) u_rsp_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rsp_push), .push_data(rx_asm),
    .pop(rsp_r_en), .pop_data(rsp_data_o), .pop_vld(rsp_data_o_vld),
    .level(rsp_level)
  );

  // Hold off request acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // TX FSM: pop a word, then launch its bytes LSB first, one per completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state          <= T_IDLE;
      tx_idx            <= '0;
      tx_word           <= '0;
      uart.byte_tx_data <= '0;
      uart.byte_tx_vld  <= 1'b0;
    end else begin
      uart.byte_tx_vld <= 1'b0;
      unique case (tx_state)
        T_IDLE: begin
          tx_idx <= '0;
          if (req_level != '0) tx_state <= T_LOAD;
        end
        T_LOAD: tx_state <= T_SEND;
        T_SEND: begin
          // The popped word is only on the FIFO read port for the first byte.
          if (req_pop_vld) begin
            tx_word           <= req_pop_data;
            uart.byte_tx_data <= req_pop_data[7:0];
          end else begin
            uart.byte_tx_data <= 8'(tx_word >> {tx_idx, 3'b000});
          end
          uart.byte_tx_vld <= 1'b1;
          tx_state         <= T_WAIT;
        end
        T_WAIT: begin
          if (uart.byte_tx_rdy) begin
            if (tx_idx == LAST_IDX) begin
              tx_state <= T_IDLE;
            end else begin
              tx_idx   <= tx_idx + IDX_W'(1);
              tx_state <= T_SEND;
            end
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

`ifdef UART_WORD_BRIDGE_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // RX FSM: pack acked bytes into a word, push or drop it on completion, plus optional idle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state         <= R_IDLE;
      rx_idx           <= '0;
      rx_asm           <= '0;
      rx_done          <= 1'b0;
      uart.byte_rx_ack <= 1'b0;
      rx_drop_cnt      <= '0;
      rsp_overflow     <= 1'b0;
`ifdef UART_WORD_BRIDGE_RX_TIMEOUT_EN
      to_cnt           <= '0;
`endif
    end else begin
      uart.byte_rx_ack <= 1'b0;
      unique case (rx_state)
        R_IDLE: begin
          if (uart.byte_rx_rdy) begin
            rx_asm           <= rx_asm | (WORD_W'(uart.byte_rx_data) << {rx_idx, 3'b000});
            rx_done          <= (rx_idx == LAST_IDX);
            rx_idx           <= (rx_idx == LAST_IDX) ? '0 : rx_idx + IDX_W'(1);
            uart.byte_rx_ack <= 1'b1;
            rx_state         <= R_ACK;
          end
        end
        R_ACK: begin
          rx_state <= R_IDLE;
          if (rx_done) begin
            // The FIFO takes rx_asm this cycle unless full; either way the word is finished.
            rx_done <= 1'b0;
            rx_asm  <= '0;
            if (rsp_full) begin
              rsp_overflow <= 1'b1;
              if (rx_drop_cnt != '1) rx_drop_cnt <= rx_drop_cnt + DROP_CNT_W'(1);
            end
          end
        end
        default: rx_state <= R_IDLE;
      endcase
`ifdef UART_WORD_BRIDGE_RX_TIMEOUT_EN
      // A capture restarts the window; a completion and a timeout never coincide since idx is 0 then.
      if (rx_capture) begin
        to_cnt <= '0;
      end else if (rx_idx != '0) begin
        if (to_cnt == TO_LAST) begin
          to_cnt <= '0;
          rx_idx <= '0;
          rx_asm <= '0;
          if (rx_drop_cnt != '1) rx_drop_cnt <= rx_drop_cnt + DROP_CNT_W'(1);
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_uart_word_bridge.sv
// Randomised scoreboard bench for uart_word_bridge with a queue-based reference model.
// Latency: checks first tx byte timing, rx ack timing and response read timing.
// Backpressure: stalls the tx side to fill the request FIFO and fills the response FIFO to force drops.
module tb_uart_word_bridge;
  localparam int WB        = 4;
  localparam int WW        = 8 * WB;
  localparam int RQI       = 5;
  localparam int RSI       = 5;
  localparam int RSP_DEPTH = 1 << RSI;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] req_data = '0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          rsp_r_en = 1'b0;
  logic [WW-1:0] rsp_data;
  logic          rsp_vld;
  logic [RQI:0]  req_level;
  logic [RSI:0]  rsp_level;
  logic [7:0]    rx_drop_cnt;
  logic          rsp_overflow;

  uart_word_bridge_if u_if ();

  uart_word_bridge #(
    .WORD_BYTES(WB), .REQ_DEPTH_IDX(RQI), .RSP_DEPTH_IDX(RSI), .RX_TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data_i(req_data), .req_vld_i(req_vld), .req_rdy_o(req_rdy),
    .rsp_r_en(rsp_r_en), .rsp_data_o(rsp_data), .rsp_data_o_vld(rsp_vld),
    .uart(u_if),
    .req_level(req_level), .rsp_level(rsp_level),
    .rx_drop_cnt(rx_drop_cnt), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and reference model state.
  logic [7:0]    exp_tx[$];
  logic [WW-1:0] exp_rsp[$];
  logic [7:0]    m_bytes[$];
  int            m_rsp_cnt = 0;
  int            m_drop = 0;
  bit            m_ovf = 1'b0;

  int tx_delay = 10;
  bit tx_stall = 1'b0;
  int tx_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Byte-launch monitor.
  always @(negedge clk) begin
    if (rst_n && u_if.byte_tx_vld) begin
      tx_seen++;
      if (exp_tx.size() == 0) check("tx_unexpected_byte", 1, 0);
      else check("tx_byte", u_if.byte_tx_data, exp_tx.pop_front());
    end
  end

  // Response-word monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_vld) begin
      if (exp_rsp.size() == 0) check("rsp_unexpected_word", 1, 0);
      else check("rsp_word", rsp_data, exp_rsp.pop_front());
    end
  end

  // UART transmitter model: completion pulse tx_delay cycles after each launch.
  initial begin
    u_if.byte_tx_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.byte_tx_vld) begin
        repeat (tx_delay) @(negedge clk);
        while (tx_stall && rst_n) @(negedge clk);
        if (rst_n) begin
          u_if.byte_tx_rdy = 1'b1;
          @(negedge clk);
          u_if.byte_tx_rdy = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_tx_data", u_if.byte_tx_data, 0);
    check("rst_tx_vld", u_if.byte_tx_vld, 0);
    check("rst_rx_ack", u_if.byte_rx_ack, 0);
    check("rst_req_level", req_level, 0);
    check("rst_rsp_level", rsp_level, 0);
    check("rst_drop_cnt", rx_drop_cnt, 0);
    check("rst_overflow", rsp_overflow, 0);
  endtask

  task automatic push_word(input logic [WW-1:0] w, output bit acc);
    req_data = w;
    req_vld  = 1'b1;
    acc      = req_rdy;
    @(negedge clk);
    req_vld = 1'b0;
    if (acc) for (int i = 0; i < WB; i++) exp_tx.push_back(8'(w >> (8 * i)));
  endtask

  task automatic model_rx(input logic [7:0] b);
    logic [WW-1:0] w;
    w = '0;
    m_bytes.push_back(b);
    if (m_bytes.size() == WB) begin
      for (int i = 0; i < WB; i++) w = w | (WW'(m_bytes[i]) << (8 * i));
      m_bytes.delete();
      if (m_rsp_cnt < RSP_DEPTH) begin
        exp_rsp.push_back(w);
        m_rsp_cnt++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    u_if.byte_rx_data = b;
    u_if.byte_rx_rdy  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!u_if.byte_rx_ack && n < 20);
    u_if.byte_rx_rdy = 1'b0;
    check("rx_ack_latency", n, 1);
    model_rx(b);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    for (int i = 0; i < WB; i++) send_byte(8'(w >> (8 * i)));
    check("rsp_level_after_word", rsp_level, m_rsp_cnt);
  endtask

  task automatic read_rsp();
    bit exp_v;
    exp_v    = (m_rsp_cnt > 0);
    rsp_r_en = 1'b1;
    @(negedge clk);
    rsp_r_en = 1'b0;
    check("rsp_vld_timing", rsp_vld, exp_v);
    if (exp_v) m_rsp_cnt--;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_remaining", exp_tx.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    u_if.byte_rx_rdy  = 1'b0;
    u_if.byte_rx_data = '0;

    // Reset state and first-cycle ready.
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    check("rdy_before_first_edge", req_rdy, 0);
    @(negedge clk);
    check("rdy_after_release", req_rdy, 1);

    // Directed tx word and first-byte latency.
    tx_delay = 10;
    push_word(32'hA1B2C3D4, acc);
    check("tx_directed_accept", acc, 1);
    n = 0;
    while (!u_if.byte_tx_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx_first_byte_latency", n, 3);
    wait_tx_drain();

    // Directed rx word and read timing, then read on empty.
    send_word(32'h44332211);
    check("rsp_level_directed", rsp_level, 1);
    read_rsp();
    check("rsp_word_directed", rsp_data, 32'h44332211);
    read_rsp();

`ifdef UART_WORD_BRIDGE_RX_TIMEOUT_EN
    // Partial word abandoned by the inter-byte timeout.
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (110) @(negedge clk);
    m_bytes.delete();
    m_drop++;
    check("timeout_drop_cnt", rx_drop_cnt, m_drop);
    send_word($urandom);
    read_rsp();
`else
    // Partial word survives a long idle gap.
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (200) @(negedge clk);
    send_byte(8'h77);
    send_byte(8'h88);
    check("partial_persist_level", rsp_level, m_rsp_cnt);
    check("partial_persist_drop", rx_drop_cnt, m_drop);
    read_rsp();
`endif

    // Request FIFO fill with the transmitter stalled.
    tx_stall = 1'b1;
    tx_delay = 1;
    push_word($urandom, acc);
    repeat (6) @(negedge clk);
    n = 0;
    for (int i = 0; i < 33; i++) begin
      push_word($urandom, acc);
      if (acc) n++;
    end
    check("stall_accepted_words", n, 32);
    check("stall_last_refused", acc, 0);
    check("stall_req_level", req_level, 32);
    check("stall_req_rdy", req_rdy, 0);
    tx_stall = 1'b0;
    wait_tx_drain();

    // Randomised mixed traffic.
    for (int i = 0; i < 12; i++) begin
      tx_delay = $urandom_range(0, 4);
      push_word($urandom, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word($urandom);
      if ($urandom_range(0, 1) == 1) read_rsp();
    end
    while (m_rsp_cnt > 0) read_rsp();
    check("random_rsp_level", rsp_level, 0);
    wait_tx_drain();

    // Response FIFO overflow.
    for (int i = 0; i < RSP_DEPTH; i++) send_word($urandom);
    check("fill_rsp_level", rsp_level, RSP_DEPTH);
    check("fill_no_overflow", rsp_overflow, 0);
    send_word($urandom);
    check("ovf_flag", rsp_overflow, m_ovf);
    check("ovf_drop_cnt", rx_drop_cnt, m_drop);
    check("ovf_rsp_level", rsp_level, RSP_DEPTH);
    while (m_rsp_cnt > 0) read_rsp();

    // Reset in the middle of a tx word with a partial rx word pending.
    send_byte(8'hA5);
    tx_delay = 10;
    push_word(32'hCAFEF00D, acc);
    n = 0;
    while (!u_if.byte_tx_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_tx.delete();
    exp_rsp.delete();
    m_bytes.delete();
    m_rsp_cnt = 0;
    m_drop = 0;
    m_ovf = 1'b0;
    tx_seen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_reset_no_tx", tx_seen, 0);
    check("post_reset_req_level", req_level, 0);
    check("post_reset_overflow", rsp_overflow, 0);
    send_word(32'h0BADBEEF);
    read_rsp();
    check("post_reset_word", rsp_data, 32'h0BADBEEF);

    repeat (5) @(negedge clk);
    check("final_exp_tx_empty", exp_tx.size(), 0);
    check("final_exp_rsp_empty", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
